// File: rtl/mm_pkg.sv
// Shared definitions for the Mastermind codebreaker and its scorer:
// code geometry, FSM state encoding, history-entry layout and the
// feedback legality test used when feedback checking is compiled in.
package mm_pkg;

   localparam int POSITIONS = 4;
   localparam int DIGIT_W   = 3;
   localparam int CODE_W    = 12;
   localparam int FB_W      = 3;
   localparam int COLOURS   = 1 << DIGIT_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OFFER,
      ST_WAIT_FB,
      ST_CHECK,
      ST_SOLVED,
      ST_FAIL
   } state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [FB_W-1:0]   red;
      logic [FB_W-1:0]   white;
   } hist_entry_t;

   // Feedback no real secret can produce: too many pegs, or 3 red + 1 white
   function automatic logic fb_illegal(input logic [FB_W-1:0] red,
                                       input logic [FB_W-1:0] white);
      logic [FB_W:0] total;
      total = {1'b0, red} + {1'b0, white};
      return (total > (FB_W+1)'(4)) ||
             ((red == FB_W'(3)) && (white == FB_W'(1))) ||
             (red > FB_W'(4)) || (white > FB_W'(4));
   endfunction

endpackage

// File: rtl/mm_score.sv
// Combinational Mastermind scorer: red = positions with equal colour,
// white = shared colours (multiset intersection) minus red.
module mm_score
   import mm_pkg::*;
(
   input  logic [CODE_W-1:0] a,
   input  logic [CODE_W-1:0] b,
   output logic [FB_W-1:0]   red,
   output logic [FB_W-1:0]   white
);

   logic [POSITIONS-1:0]    pos_eq;
   logic [COLOURS*FB_W-1:0] common_flat;
   logic [FB_W-1:0]         red_sum;
   logic [FB_W-1:0]         common_sum;

   for (genvar gi = 0; gi < POSITIONS; gi++) begin : g_pos
      assign pos_eq[gi] = (a[gi*DIGIT_W +: DIGIT_W] == b[gi*DIGIT_W +: DIGIT_W]);
   end

   for (genvar gi = 0; gi < COLOURS; gi++) begin : g_col
      logic [FB_W-1:0] cnt_a;
      logic [FB_W-1:0] cnt_b;
      // occurrences of colour gi in each code, then their minimum
      always_comb begin
         cnt_a = '0;
         cnt_b = '0;
         for (int p = 0; p < POSITIONS; p++) begin
            if (a[p*DIGIT_W +: DIGIT_W] == DIGIT_W'(gi)) cnt_a = cnt_a + FB_W'(1);
            if (b[p*DIGIT_W +: DIGIT_W] == DIGIT_W'(gi)) cnt_b = cnt_b + FB_W'(1);
         end
      end
      assign common_flat[gi*FB_W +: FB_W] = (cnt_a < cnt_b) ? cnt_a : cnt_b;
   end

   // totals of exact matches and colour matches
   always_comb begin
      red_sum    = '0;
      common_sum = '0;
      for (int p = 0; p < POSITIONS; p++)
         red_sum = red_sum + FB_W'(pos_eq[p]);
      for (int c = 0; c < COLOURS; c++)
         common_sum = common_sum + common_flat[c*FB_W +: FB_W];
   end

   assign red   = red_sum;
   assign white = common_sum - red_sum;

endmodule

// File: rtl/mm_codebreaker.sv
// Automatic Mastermind codebreaker. Offers the lowest code above the
// previous guess that is consistent with every recorded feedback entry,
// testing one history entry per cycle.
// Optional build macro MM_SOLVER_FBCHECK_EN: impossible feedback sends
// the game straight to FAIL without being recorded.
module mm_codebreaker
   import mm_pkg::*;
#(
   parameter int MAX_GUESSES = 8
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   output logic [CODE_W-1:0] guess,
   output logic              guess_valid,
   input  logic              guess_ready,
   input  logic              fb_valid,
   input  logic [FB_W-1:0]   fb_red,
   input  logic [FB_W-1:0]   fb_white,
   output logic              busy,
   output logic              solved,
   output logic              fail,
   output logic [4:0]        guess_count
);

   localparam int IDX_W = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GUESSES);
   localparam logic [CODE_W-1:0] LAST_CODE = '1;

   state_t            state_reg;
   logic [CODE_W-1:0] cand_reg;
   logic [CNT_W-1:0]  hist_cnt_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic              guess_valid_reg;
   logic              busy_reg;
   logic              solved_reg;
   logic              fail_reg;
   logic [CNT_W-1:0]  guess_count_reg;

   hist_entry_t hist_mem [MAX_GUESSES];
   hist_entry_t hist_rd;
   logic [FB_W-1:0] chk_red;
   logic [FB_W-1:0] chk_white;
   logic            chk_match;
   logic            chk_last;
   logic            fb_bad;
   logic            hist_wr;

   assign hist_rd   = hist_mem[idx_reg];
   assign chk_match = (chk_red == hist_rd.red) && (chk_white == hist_rd.white);
   assign chk_last  = ((CNT_W'(idx_reg) + CNT_W'(1)) == hist_cnt_reg);

`ifdef MM_SOLVER_FBCHECK_EN
   assign fb_bad = fb_illegal(fb_red, fb_white);
`else
   assign fb_bad = 1'b0;
`endif

   assign hist_wr = (state_reg == ST_WAIT_FB) && fb_valid && !fb_bad;

   mm_score u_score (
      .a     (cand_reg),
      .b     (hist_rd.code),
      .red   (chk_red),
      .white (chk_white)
   );

   // history storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (hist_wr)
         hist_mem[hist_cnt_reg[IDX_W-1:0]] <= {cand_reg, fb_red, fb_white};
   end

   // game control FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg       <= ST_IDLE;
         cand_reg        <= '0;
         hist_cnt_reg    <= '0;
         idx_reg         <= '0;
         guess_valid_reg <= 1'b0;
         busy_reg        <= 1'b0;
         solved_reg      <= 1'b0;
         fail_reg        <= 1'b0;
         guess_count_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_SOLVED, ST_FAIL: begin
               if (start) begin
                  state_reg       <= ST_OFFER;
                  cand_reg        <= '0;
                  hist_cnt_reg    <= '0;
                  idx_reg         <= '0;
                  guess_count_reg <= '0;
                  solved_reg      <= 1'b0;
                  fail_reg        <= 1'b0;
                  busy_reg        <= 1'b1;
                  guess_valid_reg <= 1'b1;
               end
            end
            ST_OFFER: begin
               if (guess_ready) begin
                  guess_valid_reg <= 1'b0;
                  guess_count_reg <= guess_count_reg + CNT_W'(1);
                  state_reg       <= ST_WAIT_FB;
               end
            end
            ST_WAIT_FB: begin
               if (fb_valid) begin
                  if (fb_bad) begin
                     state_reg <= ST_FAIL;
                     fail_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end else begin
                     hist_cnt_reg <= hist_cnt_reg + CNT_W'(1);
                     if (fb_red == FB_W'(4)) begin
                        state_reg  <= ST_SOLVED;
                        solved_reg <= 1'b1;
                        busy_reg   <= 1'b0;
                     end else if ((guess_count_reg == MAX_CNT) || (cand_reg == LAST_CODE)) begin
                        state_reg <= ST_FAIL;
                        fail_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                     end else begin
                        cand_reg  <= cand_reg + CODE_W'(1);
                        idx_reg   <= '0;
                        state_reg <= ST_CHECK;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (!chk_match) begin
                  if (cand_reg == LAST_CODE) begin
                     state_reg <= ST_FAIL;
                     fail_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                  end else begin
                     cand_reg <= cand_reg + CODE_W'(1);
                     idx_reg  <= '0;
                  end
               end else if (chk_last) begin
                  state_reg       <= ST_OFFER;
                  guess_valid_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign guess       = cand_reg;
   assign guess_valid = guess_valid_reg;
   assign busy        = busy_reg;
   assign solved      = solved_reg;
   assign fail        = fail_reg;
   assign guess_count = guess_count_reg;

endmodule

// File: tb/tb_mm_codebreaker.sv
// Self-checking bench for mm_codebreaker: directed scenarios plus a
// scoreboard of expected guesses/outcomes from a brute-force reference solver.
module tb_mm_codebreaker;

   localparam int LIMIT = 40000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, guess_ready, fb_valid;
   logic [2:0]  fb_red, fb_white;
   logic [11:0] guess;
   logic        guess_valid, busy, solved, fail;
   logic [4:0]  guess_count;

   logic        start_b, guess_ready_b, fb_valid_b;
   logic [2:0]  fb_red_b, fb_white_b;
   logic [11:0] guess_b;
   logic        guess_valid_b, busy_b, solved_b, fail_b;
   logic [4:0]  guess_count_b;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct packed {
      logic [1:0]  kind;   // 0 guess, 1 solved, 2 fail
      logic [11:0] code;
   } exp_t;
   exp_t exp_q[$];

   logic [11:0] h_code [16];
   logic [5:0]  h_fb   [16];
   int          h_n;

   always #5 clk = ~clk;

   mm_codebreaker #(.MAX_GUESSES(8)) dut (
      .clk(clk), .resetn(resetn), .start(start), .guess(guess),
      .guess_valid(guess_valid), .guess_ready(guess_ready), .fb_valid(fb_valid),
      .fb_red(fb_red), .fb_white(fb_white), .busy(busy), .solved(solved),
      .fail(fail), .guess_count(guess_count)
   );

   mm_codebreaker #(.MAX_GUESSES(2)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b), .guess(guess_b),
      .guess_valid(guess_valid_b), .guess_ready(guess_ready_b), .fb_valid(fb_valid_b),
      .fb_red(fb_red_b), .fb_white(fb_white_b), .busy(busy_b), .solved(solved_b),
      .fail(fail_b), .guess_count(guess_count_b)
   );

   function automatic logic [5:0] ref_score(input logic [11:0] a, input logic [11:0] b);
      int r, common;
      int ca [8];
      int cb [8];
      r = 0; common = 0;
      for (int c = 0; c < 8; c++) begin ca[c] = 0; cb[c] = 0; end
      for (int p = 0; p < 4; p++) begin
         if (a[p*3 +: 3] == b[p*3 +: 3]) r++;
         ca[a[p*3 +: 3]]++;
         cb[b[p*3 +: 3]]++;
      end
      for (int c = 0; c < 8; c++) common += (ca[c] < cb[c]) ? ca[c] : cb[c];
      return {3'(r), 3'(common - r)};
   endfunction

   function automatic logic [12:0] ref_next(input logic [11:0] prev);
      bit ok;
      for (int c = int'(prev) + 1; c < 4096; c++) begin
         ok = 1;
         for (int i = 0; i < h_n; i++)
            if (ref_score(12'(c), h_code[i]) != h_fb[i]) ok = 0;
         if (ok) return {1'b1, 12'(c)};
      end
      return 13'h0;
   endfunction

   task automatic pulse_start();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic accept();
      guess_ready = 1'b1; @(posedge clk); #1; guess_ready = 1'b0;
   endtask

   task automatic drive_fb(input logic [2:0] r, input logic [2:0] w);
      fb_valid = 1'b1; fb_red = r; fb_white = w;
      @(posedge clk); #1;
      fb_valid = 1'b0; fb_red = '0; fb_white = '0;
   endtask

   task automatic wait_event(output bit ok);
      ok = 0;
      for (int i = 0; i < LIMIT; i++) begin
         if (guess_valid || solved || fail) begin ok = 1; return; end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic test_reset();
      vec_cnt++; if (guess_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_guess_valid got %b want 0", guess_valid); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
      vec_cnt++; if ({solved, fail} !== 2'b00) begin err_cnt++; $display("FAIL reset_flags got %b want 00", {solved, fail}); end
      vec_cnt++; if (guess_count !== 5'd0) begin err_cnt++; $display("FAIL reset_count got %0d want 0", guess_count); end
      vec_cnt++; if (guess !== 12'h000) begin err_cnt++; $display("FAIL reset_guess got %h want 000", guess); end
      $display("reset: outputs sampled");
   endtask

   task automatic test_solve_zero();
      pulse_start();
      vec_cnt++; if ({guess_valid, guess} !== {1'b1, 12'h000}) begin err_cnt++; $display("FAIL zero_first_guess got %b/%h want 1/000", guess_valid, guess); end
      accept();
      drive_fb(3'd4, 3'd0);
      vec_cnt++; if (solved !== 1'b1) begin err_cnt++; $display("FAIL zero_solved got %b want 1", solved); end
      vec_cnt++; if (guess_count !== 5'd1) begin err_cnt++; $display("FAIL zero_count got %0d want 1", guess_count); end
      vec_cnt++; if ({guess_valid, busy, fail} !== 3'b000) begin err_cnt++; $display("FAIL zero_status got %b want 000", {guess_valid, busy, fail}); end
      $display("secret 000: guess 000 fb 4/0 solved=%b", solved);
   endtask

   task automatic test_secret_one();
      pulse_start();
      accept();
      drive_fb(3'd3, 3'd0);
      vec_cnt++; if (guess_valid !== 1'b0) begin err_cnt++; $display("FAIL one_early_valid got %b want 0", guess_valid); end
      @(posedge clk); #1;
      vec_cnt++; if ({guess_valid, guess} !== {1'b1, 12'h001}) begin err_cnt++; $display("FAIL one_second_guess got %b/%h want 1/001", guess_valid, guess); end
      accept();
      drive_fb(3'd4, 3'd0);
      vec_cnt++; if ({solved, guess_count} !== {1'b1, 5'd2}) begin err_cnt++; $display("FAIL one_solved got %b/%0d want 1/2", solved, guess_count); end
      $display("secret 001: guesses 000,001 solved=%b count=%0d", solved, guess_count);
   endtask

   task automatic test_backpressure();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vec_cnt++; if ({guess_valid, guess, guess_count} !== {1'b1, 12'h000, 5'd0}) begin
            err_cnt++; $display("FAIL bp_hold cyc %0d got %b/%h/%0d want 1/000/0", i, guess_valid, guess, guess_count);
         end
      end
      accept();
      vec_cnt++; if ({guess_valid, guess_count} !== {1'b0, 5'd1}) begin err_cnt++; $display("FAIL bp_handshake got %b/%0d want 0/1", guess_valid, guess_count); end
      @(posedge clk); #1;
      vec_cnt++; if (guess_count !== 5'd1) begin err_cnt++; $display("FAIL bp_once got %0d want 1", guess_count); end
      drive_fb(3'd4, 3'd0);
      $display("backpressure: 10 stall cycles, count=%0d", guess_count);
   endtask

   task automatic test_max_guesses();
      bit seen;
      start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
      guess_ready_b = 1'b1; @(posedge clk); #1; guess_ready_b = 1'b0;
      fb_valid_b = 1'b1; fb_red_b = 3'd0; fb_white_b = 3'd0; @(posedge clk); #1; fb_valid_b = 1'b0;
      seen = 0;
      for (int i = 0; i < LIMIT && !seen; i++) begin
         if (guess_valid_b || fail_b) seen = 1; else begin @(posedge clk); #1; end
      end
      vec_cnt++; if ({seen, guess_valid_b, guess_b} !== {2'b11, 12'h249}) begin
         err_cnt++; $display("FAIL max_second_guess got %b/%b/%h want 1/1/249", seen, guess_valid_b, guess_b);
      end
      guess_ready_b = 1'b1; @(posedge clk); #1; guess_ready_b = 1'b0;
      fb_valid_b = 1'b1; @(posedge clk); #1; fb_valid_b = 1'b0;
      vec_cnt++; if ({fail_b, solved_b, busy_b, guess_count_b} !== {3'b100, 5'd2}) begin
         err_cnt++; $display("FAIL max_fail got f%b s%b b%b c%0d want f1 s0 b0 c2", fail_b, solved_b, busy_b, guess_count_b);
      end
      $display("max=2: two 0/0 feedbacks fail=%b", fail_b);
   endtask

   task automatic test_illegal_fb();
      pulse_start();
      accept();
      drive_fb(3'd3, 3'd1);
`ifdef MM_SOLVER_FBCHECK_EN
      vec_cnt++; if ({fail, busy} !== 2'b10) begin err_cnt++; $display("FAIL illegal_fb got fail%b busy%b want fail1 busy0", fail, busy); end
`else
      begin
         bit ok;
         exp_t e;
         h_n = 1; h_code[0] = 12'h000; h_fb[0] = {3'd3, 3'd1};
         vec_cnt++; if ({fail, busy} !== 2'b01) begin err_cnt++; $display("FAIL illegal_fb_continue got fail%b busy%b want fail0 busy1", fail, busy); end
         e.code = ref_next(12'h000) >> 0;
         e.kind = (ref_next(12'h000) & 13'h1000) != 0 ? 2'd0 : 2'd2;
         exp_q.push_back(e);
         wait_event(ok);
         e = exp_q.pop_front();
         vec_cnt++; if ({ok, guess_valid, solved, fail} !== {1'b1, e.kind == 2'd0, 1'b0, e.kind == 2'd2}) begin
            err_cnt++; $display("FAIL illegal_fb_search got ok%b v%b s%b f%b want kind %0d", ok, guess_valid, solved, fail, e.kind);
         end
      end
`endif
      $display("illegal fb 3/1: fail=%b", fail);
   endtask

   task automatic test_reset_mid_check();
      pulse_start();
      accept();
      drive_fb(3'd0, 3'd0);
      resetn = 1'b0; @(posedge clk); #1;
      vec_cnt++; if ({busy, guess_valid, guess_count} !== {2'b00, 5'd0}) begin
         err_cnt++; $display("FAIL midreset got b%b v%b c%0d want b0 v0 c0", busy, guess_valid, guess_count);
      end
      resetn = 1'b1;
      pulse_start();
      vec_cnt++; if ({guess_valid, guess} !== {1'b1, 12'h000}) begin err_cnt++; $display("FAIL midreset_restart got %b/%h want 1/000", guess_valid, guess); end
      accept();
      drive_fb(3'd4, 3'd0);
      $display("reset during CHECK: restart offered 000");
   endtask

   task automatic play_game(input logic [11:0] secret);
      bit ok;
      exp_t e;
      logic [5:0] fb;
      logic [12:0] nx;
      logic [1:0] obs;
      int cnt;
      h_n = 0; cnt = 0;
      exp_q.push_back({2'd0, 12'h000});
      pulse_start();
      while (exp_q.size() > 0) begin
         wait_event(ok);
         e = exp_q.pop_front();
         obs = guess_valid ? 2'd0 : solved ? 2'd1 : fail ? 2'd2 : 2'd3;
         vec_cnt++;
         if (!ok || obs !== e.kind) begin
            err_cnt++; $display("FAIL game_%h_kind got %0d want %0d (ok=%b)", secret, obs, e.kind, ok);
         end else if (e.kind == 2'd0) begin
            vec_cnt++; if (guess !== e.code) begin err_cnt++; $display("FAIL game_%h_guess got %h want %h", secret, guess, e.code); end
            accept();
            cnt++;
            fb = ref_score(secret, e.code);
            h_code[h_n] = e.code; h_fb[h_n] = fb; h_n++;
            $display("game %h: guess %h fb %0d/%0d", secret, e.code, fb[5:3], fb[2:0]);
            drive_fb(fb[5:3], fb[2:0]);
            if (fb[5:3] == 3'd4) exp_q.push_back({2'd1, 12'h000});
            else if (cnt == 8) exp_q.push_back({2'd2, 12'h000});
            else begin
               nx = ref_next(e.code);
               if (nx[12]) exp_q.push_back({2'd0, nx[11:0]});
               else exp_q.push_back({2'd2, 12'h000});
            end
         end else begin
            vec_cnt++; if (guess_count !== 5'(cnt)) begin err_cnt++; $display("FAIL game_%h_count got %0d want %0d", secret, guess_count, cnt); end
         end
      end
   endtask

   task automatic test_random_games();
      play_game(12'h5A3);
      play_game(12'($urandom_range(0, 4095)));
   endtask

   initial begin
      start = 0; guess_ready = 0; fb_valid = 0; fb_red = 0; fb_white = 0;
      start_b = 0; guess_ready_b = 0; fb_valid_b = 0; fb_red_b = 0; fb_white_b = 0;
      #1;
      do_reset();
      test_reset();
      test_solve_zero();
      test_secret_one();
      test_backpressure();
      test_max_guesses();
      test_illegal_fb();
      test_reset_mid_check();
      test_random_games();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
